axi_lite_regfile: RTL and testbench

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

---
 rtl/axi_lite_pkg.sv | 30 +++
 rtl/axi_lite_regfile.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-lite register file: response codes, channel FSM states
// and the word-index helpers used to decode byte addresses into register slots.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Registers are word aligned; byte-offset bits below this are ignored.
    localparam int unsigned WORD_LSB = 2;

    // Index bits needed to cover NUM_RW r/w words plus the status and ID words.
    function automatic int unsigned idx_width(input int unsigned num_rw);
        return $clog2(num_rw + 2);
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// AXI-lite slave: NUM_RW r/w registers, a live status word and a constant ID word.
// Write response / read data one cycle after the completing handshake; one txn per channel, held until B/RREADY.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_RW     = 6,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11E_0001
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [DATA_WIDTH/8-1:0]      WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic [DATA_WIDTH-1:0]        hw_status,
    output logic [NUM_RW*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_RW-1:0]            wr_pulse
);

    localparam int             IDX_W      = idx_width(NUM_RW);
    localparam int             STRB_W     = DATA_WIDTH / 8;
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NUM_RW);
    localparam logic [IDX_W-1:0] IDX_ID     = IDX_W'(NUM_RW + 1);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (IDX_W + WORD_LSB)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+WORD_LSB-1:WORD_LSB];
    endfunction

    // Holds all readies low until the first edge after reset release.
    logic ready_en_q;

    wr_state_t               wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    resp_t                   bresp_q, bresp_d;

    rd_state_t               rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    resp_t                   rresp_q, rresp_d;

    logic [NUM_RW-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_RW-1:0]                 wr_pulse_q, wr_pulse_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit, wr_ok;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [DATA_WIDTH-1:0] eff_data;
    logic [STRB_W-1:0]     eff_strb;
    logic [IDX_W-1:0]      wr_idx, ar_idx;
    logic                  unused_addr_lsbs;

    assign AWREADY = ready_en_q && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_DATA);
    assign WREADY  = ready_en_q && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_ADDR);
    assign ARREADY = ready_en_q && (rd_state_q == R_IDLE);
    assign BVALID  = (wr_state_q == W_RESP);
    assign BRESP   = bresp_q;
    assign RVALID  = (rd_state_q == R_DATA);
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;
    assign reg_q   = regs_q;
    assign wr_pulse = wr_pulse_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // The commit cycle merges whichever half arrives now with the half already held.
    assign eff_addr = aw_hs ? AWADDR : awaddr_q;
    assign eff_data = w_hs  ? WDATA  : wdata_q;
    assign eff_strb = w_hs  ? WSTRB  : wstrb_q;
    assign wr_idx   = idx_of(eff_addr);
    assign wr_ok    = in_range(eff_addr) && (wr_idx < IDX_STATUS);
    assign ar_idx   = idx_of(ARADDR);
    assign unused_addr_lsbs = ^{eff_addr[WORD_LSB-1:0], ARADDR[WORD_LSB-1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_d = W_RESP;
                    commit     = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = W_HAVE_ADDR;
                    awaddr_d   = AWADDR;
                end else if (w_hs) begin
                    wr_state_d = W_HAVE_DATA;
                    wdata_d    = WDATA;
                    wstrb_d    = WSTRB;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    wr_state_d = W_RESP;
                    commit     = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    wr_state_d = W_RESP;
                    commit     = 1'b1;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (commit) begin
            bresp_d = wr_ok ? OKAY : SLVERR;
        end
    end

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (commit && wr_ok) begin
            wr_pulse_d[wr_idx] = 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
                if (eff_strb[b]) begin
                    regs_d[wr_idx][8*b +: 8] = eff_data[8*b +: 8];
                end
            end
        end
    end

    // Reads sample regs_q, so a write committing on the same edge is not visible yet.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    rdata_d    = '0;
                    rresp_d    = OKAY;
                    if (!in_range(ARADDR)) begin
                        rresp_d = SLVERR;
                    end else if (ar_idx < IDX_STATUS) begin
                        rdata_d = regs_q[ar_idx];
                    end else if (ar_idx == IDX_STATUS) begin
                        rdata_d = hw_status;
                    end else if (ar_idx == IDX_ID) begin
                        rdata_d = ID_VALUE;
                    end else begin
                        rresp_d = SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ready_en_q <= 1'b0;
            wr_state_q <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
        end else begin
            ready_en_q <= 1'b1;
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: table of write/read-back vectors plus
// hand-written sequences for timing, backpressure, same-edge read/write and mid-transaction reset.
module tb_axi_lite_regfile;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [31:0]  AWADDR;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [31:0]  ARADDR;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [31:0]  hw_status;
    logic [191:0] reg_q;
    logic [5:0]   wr_pulse;

    int checks = 0;
    int errors = 0;

    axi_lite_regfile dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .hw_status(hw_status),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          mode;    // 0: AW+W together, 1: W first, 2: AW first
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] mdl [6];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [191:0] mdl_flat();
        logic [191:0] f;
        for (int i = 0; i < 6; i++) f[i*32 +: 32] = mdl[i];
        return f;
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_readys_valids"}, {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
        check({tag, "_bresp"}, BRESP, 2'b00);
        check({tag, "_rresp"}, RRESP, 2'b00);
        check({tag, "_rdata"}, RDATA, 32'h0);
        check({tag, "_reg_q"}, reg_q, 192'h0);
        check({tag, "_wr_pulse"}, wr_pulse, 6'h0);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, output logic [1:0] resp);
        bit aw_done, w_done, aw_h, w_h;
        int n;
        aw_done = 0; w_done = 0; n = 0; resp = 2'b11;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = (mode != 1);
        WVALID  = (mode != 2);
        while (!(aw_done && w_done) && n < 20) begin
            aw_h = AWVALID && AWREADY;
            w_h  = WVALID && WREADY;
            tick();
            n++;
            if (aw_h) begin aw_done = 1; AWVALID = 0; end
            if (w_h)  begin w_done = 1;  WVALID = 0;  end
            if (!aw_done) AWVALID = 1;
            if (!w_done)  WVALID = 1;
        end
        AWVALID = 0; WVALID = 0;
        n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        if (!BVALID) begin
            timeout("write_bvalid");
        end else begin
            resp = BRESP;
            BREADY = 1;
            tick();
            BREADY = 0;
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0; d = 32'hX; resp = 2'b11;
        ARADDR = a;
        ARVALID = 1;
        while (!ARREADY && n < 20) begin tick(); n++; end
        tick();
        ARVALID = 0;
        n = 0;
        while (!RVALID && n < 20) begin tick(); n++; end
        if (!RVALID) begin
            timeout("read_rvalid");
        end else begin
            d = RDATA;
            resp = RRESP;
            RREADY = 1;
            tick();
            RREADY = 0;
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;

        tbl[0] = '{32'h08, 32'h0000_0001, 4'hF, 0, 2'b00, 32'h0000_0001, 2'b00};
        tbl[1] = '{32'h0C, 32'hAABB_CCDD, 4'h8, 2, 2'b00, 32'hAA00_0000, 2'b00};
        tbl[2] = '{32'h0C, 32'h1122_3344, 4'h2, 1, 2'b00, 32'hAA00_3300, 2'b00};
        tbl[3] = '{32'h14, 32'hCAFE_F00D, 4'hF, 0, 2'b00, 32'hCAFE_F00D, 2'b00};
        tbl[4] = '{32'h18, 32'h0000_0055, 4'hF, 0, 2'b10, 32'h5A5A_0000, 2'b00};
        tbl[5] = '{32'h1C, 32'h0000_0066, 4'hF, 2, 2'b10, 32'hA11E_0001, 2'b00};
        tbl[6] = '{32'h40, 32'h0000_0077, 4'hF, 1, 2'b10, 32'h0000_0000, 2'b10};
        tbl[7] = '{32'h13, 32'h0BAD_F00D, 4'hF, 0, 2'b00, 32'h0BAD_F00D, 2'b00};
        tbl[8] = '{32'h20, 32'h0000_0099, 4'hF, 0, 2'b10, 32'h0000_0000, 2'b10};
        for (int i = 0; i < 6; i++) mdl[i] = 32'h0;

        ARESETn = 0;
        AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARVALID = 0; RREADY = 0;
        hw_status = 32'h5A5A_0000;

        tick(); tick();
        reset_checks("reset");
        ARESETn = 1;
        #1;
        check("ready_before_first_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
        tick();
        check("ready_after_first_edge", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Simultaneous AW/W to word 1, then B backpressure for 5 cycles.
        AWADDR = 32'h04; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
        AWVALID = 1; WVALID = 1;
        tick();
        AWVALID = 0; WVALID = 0;
        check("t1_bvalid", BVALID, 1'b1);
        check("t1_bresp", BRESP, 2'b00);
        check("t1_wr_pulse", wr_pulse, 6'b000010);
        check("t1_reg1", reg_q[63:32], 32'hDEAD_BEEF);
        tick();
        check("t1_wr_pulse_clear", wr_pulse, 6'b000000);
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid_bresp", {BVALID, BRESP}, 3'b100);
            check("bhold_readys", {AWREADY, WREADY}, 2'b00);
            tick();
        end
        BREADY = 1;
        tick();
        BREADY = 0;
        check("t1_after_bready", {BVALID, AWREADY, WREADY}, 3'b011);
        mdl[1] = 32'hDEAD_BEEF;

        // W one cycle ahead of AW with sparse strobes.
        axi_write(32'h00, 32'h1234_5678, 4'b0101, 1, resp);
        check("t2_bresp", resp, 2'b00);
        check("t2_reg0", reg_q[31:0], 32'h0034_0078);
        mdl[0] = 32'h0034_0078;

        for (int i = 0; i < 9; i++) begin
            axi_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].mode, resp);
            check($sformatf("vec%0d_bresp", i), resp, tbl[i].bresp);
            if (tbl[i].bresp == 2'b00) mdl[(tbl[i].addr >> 2) & 32'h7] = tbl[i].rdata;
            check($sformatf("vec%0d_reg_q", i), reg_q, mdl_flat());
            axi_read(tbl[i].addr, rd, resp);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
            check($sformatf("vec%0d_rresp", i), resp, tbl[i].rresp);
        end

        // R backpressure for 5 cycles.
        ARADDR = 32'h04; ARVALID = 1;
        tick();
        ARVALID = 0;
        for (int i = 0; i < 5; i++) begin
            check("rhold_rvalid_rdata", {RVALID, RDATA}, {1'b1, 32'hDEAD_BEEF});
            check("rhold_arready", ARREADY, 1'b0);
            tick();
        end
        RREADY = 1;
        tick();
        RREADY = 0;
        check("rhold_release", {RVALID, ARREADY}, 2'b01);

        // Read and write commit of word 2 on the same edge.
        ARADDR = 32'h08; ARVALID = 1;
        AWADDR = 32'h08; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        tick();
        ARVALID = 0; AWVALID = 0; WVALID = 0;
        check("same_edge_rdata_old", {RVALID, RDATA}, {1'b1, 32'h0000_0001});
        check("same_edge_bresp", {BVALID, BRESP}, 3'b100);
        RREADY = 1; BREADY = 1;
        tick();
        RREADY = 0; BREADY = 0;
        axi_read(32'h08, rd, resp);
        check("same_edge_rdata_new", rd, 32'hFFFF_FFFF);

        // Reset while holding an address only.
        AWADDR = 32'h10; AWVALID = 1;
        tick();
        AWVALID = 0;
        check("have_addr_readys", {AWREADY, WREADY}, 2'b01);
        ARESETn = 0;
        #2;
        reset_checks("midreset");
        ARESETn = 1;
        tick();
        check("midreset_ready_back", {AWREADY, WREADY, ARREADY}, 3'b111);
        axi_write(32'h0C, 32'h0000_0077, 4'hF, 0, resp);
        check("post_reset_bresp", resp, 2'b00);
        check("post_reset_reg_q", reg_q, {64'h0, 32'h0000_0077, 96'h0});
        axi_read(32'h0C, rd, resp);
        check("post_reset_rdata", {rd, resp}, {32'h0000_0077, 2'b00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
